// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_data, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction
// memory and releases the CPU from reset only after a clean load.
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_req,
    prog_loader_if.slave   bus,
    output logic           cpu_rst,
    output logic           done,
    output logic           error
);

    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0]   MAX_N = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    state_t            state, state_n;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic              len_bad;
    logic [ADDR_W:0]   nwords;
    logic [ADDR_W:0]   wcnt;
    logic [ADDR_W:0]   wcnt_inc;
    logic [1:0]        bcnt;
    logic [23:0]       wbuf;
    logic [7:0]        csum;
    logic              accept;
    logic              word_done;

    assign accept   = bus.byte_valid && bus.byte_ready;
    assign len      = {bus.byte_data, len_lo};
    assign len_bad  = {1'b0, len} > MAX_N;
    assign wcnt_inc = wcnt + ONE;

    always_comb begin
        state_n   = state;
        word_done = 1'b0;
        if (load_req) begin
            state_n = S_LEN0;
        end else if (accept) begin
            unique case (state)
                S_LEN0: state_n = S_LEN1;
                S_LEN1: begin
                    if (len_bad)
                        state_n = S_ERR;
                    else if (len == 16'd0)
                        state_n = S_CSUM;
                    else
                        state_n = S_DATA;
                end
                S_DATA: begin
                    if (bcnt == 2'd3) begin
                        word_done = 1'b1;
                        if (wcnt_inc == nwords)
                            state_n = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (bus.byte_data == csum)
                        state_n = S_DONE;
                    else
                        state_n = S_ERR;
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_LEN0;
            bus.byte_ready <= 1'b1;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_rst        <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            len_lo         <= '0;
            nwords         <= '0;
            wcnt           <= '0;
            bcnt           <= '0;
            wbuf           <= '0;
            csum           <= '0;
        end else begin
            state          <= state_n;
            bus.byte_ready <= state_n inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
            cpu_rst        <= state_n != S_DONE;
            done           <= state_n == S_DONE;
            error          <= state_n == S_ERR;
            bus.imem_we    <= word_done;
            if (load_req) begin
                wcnt <= '0;
                bcnt <= '0;
                wbuf <= '0;
                csum <= '0;
            end else if (accept) begin
                if (state == S_LEN0)
                    len_lo <= bus.byte_data;
                if (state == S_LEN1)
                    nwords <= len[ADDR_W:0];
                if (state == S_DATA) begin
                    csum <= csum ^ bus.byte_data;
                    bcnt <= bcnt + 2'd1;
                    wbuf <= {bus.byte_data, wbuf[23:8]};
                end
                // wbuf already holds bytes 0..2 in little-endian order
                if (word_done) begin
                    bus.imem_addr  <= wcnt[ADDR_W-1:0];
                    bus.imem_wdata <= {bus.byte_data, wbuf};
                    wcnt           <= wcnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes and
// final status, a negedge monitor pops and compares.
module tb_prog_loader;

    localparam int ADDR_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic load_req;
    logic cpu_rst, done, error;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .bus      (bus),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   wr_seen = 0;
    wr_t  exp_wr[$];
    logic [3:0] exp_st[$];
    logic st_prev = 1'b0;

    // status vector: {done, error, cpu_rst, byte_ready}
    always @(negedge clk) begin
        wr_t e;
        logic [3:0] s;
        if (bus.imem_we === 1'b1) begin
            wr_seen++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required none",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                e = exp_wr.pop_front();
                if (e.addr !== bus.imem_addr || e.data !== bus.imem_wdata) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             bus.imem_addr, bus.imem_wdata, e.addr, e.data);
                end
            end
        end
        if ((done || error) && !st_prev) begin
            checks++;
            if (exp_st.size() == 0) begin
                errors++;
                $display("FAIL unexpected_status: got %b, required none",
                         {done, error, cpu_rst, bus.byte_ready});
            end else begin
                s = exp_st.pop_front();
                if (s !== {done, error, cpu_rst, bus.byte_ready}) begin
                    errors++;
                    $display("FAIL status: got %b, required %b",
                             {done, error, cpu_rst, bus.byte_ready}, s);
                end
            end
        end
        st_prev = done || error;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
        end
        @(negedge clk);
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 20) begin
            bus.byte_valid = 1'b0;
            @(negedge clk);
            t++;
        end
        if (bus.byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got byte_ready=%b, required 1", bus.byte_ready);
        end
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic start_load();
        @(negedge clk);
        bus.byte_valid = 1'b0;
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic finish_scn(input string nm, input int nwr);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk({nm, "_wr_count"}, 32'(wr_seen), 32'(nwr));
        chk({nm, "_wr_pending"}, 32'(exp_wr.size()), 32'd0);
        chk({nm, "_st_pending"}, 32'(exp_st.size()), 32'd0);
        wr_seen = 0;
    endtask

    task automatic send_list(input logic [7:0] v[$], input bit gaps);
        foreach (v[i])
            send(v[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st[$];
        rst = 1'b1;
        load_req = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.byte_ready), 32'd1);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        rst = 1'b0;

        // two words, back-to-back, good checksum
        exp_wr.push_back('{8'd0, 32'h12345678});
        exp_wr.push_back('{8'd1, 32'hDEADBEEF});
        exp_st.push_back(4'b1000);
        st = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send_list(st, 1'b0);
        finish_scn("two_words", 2);

        // reset after a load clears the write port
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_mid_wdata", bus.imem_wdata, 32'd0);
        chk("rst_mid_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_mid_done", 32'(done), 32'd0);

        // same stream, bad checksum, random gaps
        start_load();
        exp_wr.push_back('{8'd0, 32'h12345678});
        exp_wr.push_back('{8'd1, 32'hDEADBEEF});
        exp_st.push_back(4'b0110);
        st = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
        send_list(st, 1'b1);
        finish_scn("bad_csum_gaps", 2);

        // empty program, good and bad checksum
        start_load();
        exp_st.push_back(4'b1000);
        st = '{8'h00, 8'h00, 8'h00};
        send_list(st, 1'b0);
        finish_scn("empty_ok", 0);
        start_load();
        exp_st.push_back(4'b0110);
        st = '{8'h00, 8'h00, 8'h01};
        send_list(st, 1'b0);
        finish_scn("empty_bad", 0);

        // oversize length: 257 words
        start_load();
        exp_st.push_back(4'b0110);
        send(8'h01, 0);
        send(8'h01, 0);
        @(negedge clk);
        chk("oversize_err_next", 32'(error), 32'd1);
        chk("oversize_ready", 32'(bus.byte_ready), 32'd0);
        finish_scn("oversize", 0);

        // abort mid-word; load_req beats the concurrent byte
        start_load();
        st = '{8'h01, 8'h00, 8'h11, 8'h22};
        send_list(st, 1'b0);
        @(negedge clk);
        bus.byte_data = 8'h33;
        bus.byte_valid = 1'b1;
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.byte_ready), 32'd1);
        chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("abort_we", 32'(bus.imem_we), 32'd0);
        exp_wr.push_back('{8'd0, 32'hDDCCBBAA});
        exp_st.push_back(4'b1000);
        st = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_list(st, 1'b0);
        finish_scn("abort_reload", 1);

        // full depth: 256 words, word k = {k,k,k,k}, checksum 0
        start_load();
        send(8'h00, 0);
        send(8'h01, 0);
        for (int k = 0; k < 256; k++) begin
            exp_wr.push_back('{8'(k), {4{8'(k)}}});
            repeat (4) send(8'(k), 0);
        end
        exp_st.push_back(4'b1000);
        send(8'h00, 0);
        finish_scn("full_depth", 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, meaning instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_req  input  1  one-cycle pulse; aborts any load and restarts at the length field.
REQ-005 byte_data  input  8  incoming program stream byte.
REQ-006 byte_valid  input  1  byte_data valid this cycle.
REQ-007 byte_ready  output  1  loader accepts a byte; transfer occurs when byte_valid && byte_ready at the rising edge.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address for the write.
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 cpu_rst  output  1  holds the CPU in reset while high.
REQ-012 done  output  1  load completed with correct checksum.
REQ-013 error  output  1  load failed (oversize length or checksum mismatch).

Function
REQ-014 Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, then one checksum byte.
REQ-015 States: S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR; all outputs registered.
REQ-016 S_LEN0 -> S_LEN1 on accepted byte (latch LEN_LO).
REQ-017 S_LEN1 on accepted byte: N > 2^ADDR_W -> S_ERR; N == 0 -> S_CSUM; else -> S_DATA.
REQ-018 Data bytes assemble little-endian: first byte of each group -> bits [7:0], fourth -> [31:24].
REQ-019 One cycle after the 4th byte of word k is accepted: imem_we=1 for exactly one cycle, imem_addr=k, imem_wdata=assembled word; k starts at 0 and increments per word.
REQ-020 byte_ready stays high in S_LEN0..S_CSUM, including the imem_we cycle; back-to-back bytes every cycle are supported without loss.
REQ-021 Gaps (byte_valid low) stall the FSM with no state, counter or checksum change.
REQ-022 After word N-1 is accepted -> S_CSUM.
REQ-023 Running checksum = XOR of all data bytes only (length bytes excluded), cleared on entry to S_LEN0; N == 0 expects 0x00.
REQ-024 S_CSUM on accepted byte: match -> S_DONE; mismatch -> S_ERR.
REQ-025 S_DONE: done=1, cpu_rst=0 (both asserted the cycle after the checksum byte is accepted), byte_ready=0.
REQ-026 S_ERR: error=1, cpu_rst=1, byte_ready=0; reached the cycle after the offending byte.
REQ-027 cpu_rst=1 in every state except S_DONE.
REQ-028 load_req in any state -> S_LEN0 next cycle: word counter, checksum and partial word cleared, done=0, error=0, cpu_rst=1, no imem_we for a partial word; load_req wins over a simultaneous byte transfer (that byte is discarded).
REQ-029 A pending imem_we for a completed word still issues in the cycle load_req is sampled; no further writes follow.
REQ-030 Word counter width ADDR_W+1; no address wrap occurs because N is bounded by REQ-017.

Reset
REQ-031 On rst: state S_LEN0, byte_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, error=0, counters and checksum 0.
REQ-032 rst mid-load behaves as load_req and additionally zeroes imem_addr/imem_wdata; rst has priority over load_req and byte transfers.

Verification
REQ-033 Reset check: assert rst 2 cycles -> byte_ready=1, cpu_rst=1, done=0, error=0, imem_we=0.
REQ-034 Stream 02 00 78 56 34 12 EF BE AD DE 2A, one byte per cycle -> writes addr0=0x12345678, addr1=0xDEADBEEF, done=1, cpu_rst=0, exactly 2 imem_we pulses.
REQ-035 Same stream with checksum 2B and random byte_valid gaps -> same 2 writes, then error=1, cpu_rst=1, byte_ready=0, done=0.
REQ-036 Stream 00 00 00 -> done=1, cpu_rst=0, no imem_we; stream 00 00 01 -> error=1.
REQ-037 ADDR_W=8, stream 01 01 -> error=1 the cycle after LEN_HI, no writes, byte_ready=0.
REQ-038 Stream 01 00 11 22 then load_req (same cycle as byte 33) -> no write, FSM in S_LEN0; then 01 00 AA BB CC DD 00 -> write addr0=0xDDCCBBAA, done=1.
